// File: rtl/bin_to_ascii_stream.sv
// Streaming binary-to-ASCII converter: buffers packed words in a small FIFO and
// emits one raw-printable or hex character per cycle over a valid/ready stream.
module bin_to_ascii_stream #(
  parameter int          BYTES      = 6,
  parameter int          FIFO_DEPTH = 4,
  parameter int          HEX_UPPER  = 1,
  parameter logic [7:0]  TERM_CHAR  = 8'h0A
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [8*BYTES-1:0] in_data,
  input  logic               in_mode_hex,
  input  logic               in_term_en,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [7:0]         out_char,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic [15:0]        word_count
);

  localparam int W  = 8 * BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(2 * BYTES + 2);

  localparam logic [IW-1:0] LAST_RAW = IW'(BYTES - 1);
  localparam logic [IW-1:0] LAST_HEX = IW'(2 * BYTES - 1);
  localparam logic [7:0]    HEX_A    = (HEX_UPPER != 0) ? 8'h41 : 8'h61;

  typedef struct packed {
    logic         hex;
    logic         term;
    logic [W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, EMIT, TERM} state_t;

  function automatic logic [IW-1:0] last_idx(input logic hex);
    return hex ? LAST_HEX : LAST_RAW;
  endfunction

  // Character at position idx of a word's data characters (excluding terminator).
  function automatic logic [7:0] char_of(input logic [W-1:0] d, input logic hex,
                                         input logic [IW-1:0] idx);
    logic [W-1:0] sh;
    logic [7:0]   b;
    logic [3:0]   n;
    int           bi;
    bi = hex ? int'(idx >> 1) : int'(idx);
    sh = d >> (8 * (BYTES - 1 - bi));
    b  = sh[7:0];
    n  = idx[0] ? b[3:0] : b[7:4];
    if (!hex)
      return (b >= 8'h20 && b <= 8'h7E) ? b : 8'h2E;
    else if (n < 4'd10)
      return 8'h30 + {4'h0, n};
    else
      return HEX_A + {4'h0, n} - 8'd10;
  endfunction

  // Word FIFO
  entry_t         mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr_q, rd_ptr_q;
  logic           fifo_empty, fifo_full, push, pop;
  entry_t         head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;
  assign head       = mem[rd_ptr_q[AW-1:0]];

  // NOTE: the storage array has no reset; the pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= '{hex: in_mode_hex, term: in_term_en, data: in_data};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Emit FSM and shift register
  state_t        state_q, state_d;
  logic [W-1:0]  word_q, word_d;
  logic          hex_q, hex_d, term_q, term_d;
  logic [IW-1:0] idx_q, idx_d, idx_nxt;
  logic [7:0]    char_q, char_d;
  logic          valid_q, valid_d, last_q, last_d;
  logic [15:0]   count_q, count_d;
  logic          hs, load, done;

  assign hs      = valid_q && out_ready;
  assign idx_nxt = idx_q + 1'b1;

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    hex_d   = hex_q;
    term_d  = term_q;
    idx_d   = idx_q;
    char_d  = char_q;
    valid_d = valid_q;
    last_d  = last_q;
    count_d = count_q;
    load    = 1'b0;
    done    = 1'b0;
    pop     = 1'b0;

    if (hs && last_q) count_d = count_q + 16'd1;

    case (state_q)
      IDLE: load = !fifo_empty;
      EMIT: begin
        if (hs) begin
          if (idx_q == last_idx(hex_q)) begin
            if (term_q) begin
              state_d = TERM;
              char_d  = TERM_CHAR;
              last_d  = 1'b1;
            end else begin
              done = 1'b1;
            end
          end else begin
            idx_d  = idx_nxt;
            char_d = char_of(word_q, hex_q, idx_nxt);
            last_d = (idx_nxt == last_idx(hex_q)) && !term_q;
          end
        end
      end
      TERM: done = hs;
      default: state_d = IDLE;
    endcase

    // Completion chains straight into the next buffered word, so no bubble.
    if (done) begin
      if (!fifo_empty) begin
        load = 1'b1;
      end else begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    end

    if (load) begin
      pop     = 1'b1;
      state_d = EMIT;
      word_d  = head.data;
      hex_d   = head.hex;
      term_d  = head.term;
      idx_d   = '0;
      char_d  = char_of(head.data, head.hex, '0);
      valid_d = 1'b1;
      last_d  = (last_idx(head.hex) == '0) && !head.term;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      hex_q   <= 1'b0;
      term_q  <= 1'b0;
      idx_q   <= '0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      hex_q   <= hex_d;
      term_q  <= term_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  assign out_char   = char_q;
  assign out_valid  = valid_q;
  assign out_last   = last_q;
  assign word_count = count_q;
  assign busy       = !fifo_empty || (state_q != IDLE);

endmodule
